// File: rtl/keep_one_in_n_unzip_pkg.sv
// Shared types and constants for the packed-IQ unzipper.
// Symbol selection helper keeps the MSB-first word ordering in one place.
package keep_one_in_n_unzip_pkg;

    localparam int SYM_W  = 8;
    localparam int NIB_W  = 4;
    localparam int LANE_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        EMIT  = 1'b1
    } unzip_state_e;

    // Index 0 selects the most significant symbol of the word.
    function automatic logic [SYM_W-1:0] sym_sel(input logic [4*SYM_W-1:0] word,
                                                 input logic [1:0]         idx);
        logic [SYM_W-1:0] sym;
        case (idx)
            2'd0:    sym = word[31:24];
            2'd1:    sym = word[23:16];
            2'd2:    sym = word[15:8];
            default: sym = word[7:0];
        endcase
        return sym;
    endfunction

endpackage

// File: rtl/unzip_sym_expand.sv
// Expands one 8-bit IQ symbol (I[7:4], Q[3:0]) into a 32-bit sample, I in [31:16].
// UNZIP_MSB_ALIGN_EN selects full-scale MSB placement instead of sign extension.
module unzip_sym_expand
    import keep_one_in_n_unzip_pkg::*;
(
    input  logic [SYM_W-1:0]    sym_i,
    output logic [2*LANE_W-1:0] sample_o
);

    logic [NIB_W-1:0] i_nib_s;
    logic [NIB_W-1:0] q_nib_s;

    assign i_nib_s = sym_i[SYM_W-1:NIB_W];
    assign q_nib_s = sym_i[NIB_W-1:0];

`ifdef UNZIP_MSB_ALIGN_EN
    assign sample_o = {i_nib_s, {(LANE_W-NIB_W){1'b0}},
                       q_nib_s, {(LANE_W-NIB_W){1'b0}}};
`else
    assign sample_o = {{(LANE_W-NIB_W){i_nib_s[NIB_W-1]}}, i_nib_s,
                       {(LANE_W-NIB_W){q_nib_s[NIB_W-1]}}, q_nib_s};
`endif

endmodule

// File: rtl/keep_one_in_n_unzip.sv
// Unpacks each 32-bit word of four IQ symbols into four consecutive output samples.
// Optional macro UNZIP_MSB_ALIGN_EN changes only the sample format (see unzip_sym_expand).
module keep_one_in_n_unzip
    import keep_one_in_n_unzip_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SYMS  = 4
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready
);

    localparam int         IDX_W    = 2;
    localparam logic [1:0] LAST_IDX = IDX_W'(SYMS - 1);

    unzip_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             last_q, last_d;
    logic             load_s;
    logic             emit_last_s;

    // A word may enter while idle, or as the final symbol of the current word drains.
    assign emit_last_s = (state_q == EMIT) && (idx_q == LAST_IDX);
    assign i_tready    = (state_q == EMPTY) || (emit_last_s && o_tready);
    assign load_s      = i_tvalid && i_tready;

    // Next-state: load, advance the symbol index, or fall back to idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            EMPTY: begin
                if (load_s) begin
                    state_d = EMIT;
                end else begin
                    state_d = EMPTY;
                end
            end
            EMIT: begin
                if (load_s) begin
                    state_d = EMIT;
                end else if (emit_last_s && o_tready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = EMIT;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (load_s) begin
            hold_d = i_tdata;
            last_d = i_tlast;
            idx_d  = '0;
        end else if ((state_q == EMIT) && o_tready && !emit_last_s) begin
            idx_d = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
    end

    // State, index and holding register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    unzip_sym_expand u_expand (
        .sym_i    (sym_sel(hold_q, idx_q)),
        .sample_o (o_tdata)
    );

    assign o_tvalid = (state_q == EMIT);
    assign o_tlast  = emit_last_s && last_q;

endmodule
